// File: rtl/dft64_sample_loader.sv
// -----------------------------------------------------------------------------
// dft64_sample_loader
//
// Purpose:
//   Upstream feeder for dft64. It collects a serial stream of signed samples
//   into an N_POINTS-entry frame buffer. It then bursts the frame into dft64
//   as BEATS beats of LANES packed samples, with rel asserted on every beat.
//   After the burst it waits for dft64 done, or for a bounded timeout, and
//   only then accepts the next frame.
//
// Ports:
//   clk          in   1                 system clock, all logic on posedge
//   sreset       in   1                 synchronous active-high reset
//   in_sample    in   SAMPLE_W          incoming sample
//   in_valid     in   1                 in_sample is valid this cycle
//   in_ready     out  1                 loader accepts a sample this cycle
//   samples      out  LANES*SAMPLE_W    packed beat to dft64, lane 0 in MSBs
//   rel          out  1                 beat valid to dft64
//   done         in   1                 dft64 result-valid
//   busy         out  1                 frame in BURST or WAIT
//   timeout_err  out  1                 1-cycle pulse: done not seen in time
//   frame_cnt    out  8                 frames completed with done (wraps)
//
// N_POINTS must equal LANES * BEATS, and LANES must be a power of two.
// -----------------------------------------------------------------------------
module dft64_sample_loader #(
    parameter int SAMPLE_W     = 16,
    parameter int N_POINTS     = 64,
    parameter int LANES        = 8,
    parameter int DONE_TIMEOUT = 6
) (
    input  logic                      clk,
    input  logic                      sreset,
    input  logic [SAMPLE_W-1:0]       in_sample,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [LANES*SAMPLE_W-1:0] samples,
    output logic                      rel,
    input  logic                      done,
    output logic                      busy,
    output logic                      timeout_err,
    output logic [7:0]                frame_cnt
);

    localparam int BEATS  = N_POINTS / LANES;
    localparam int PTR_W  = $clog2(N_POINTS);
    localparam int LANE_W = $clog2(LANES);
    localparam int BEAT_W = $clog2(BEATS);
    localparam int WAIT_W = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_BURST = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    w_wptr_next;
    logic [BEAT_W-1:0]   r_beat;
    logic [BEAT_W-1:0]   w_beat_next;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [WAIT_W-1:0]   w_wait_cnt_next;
    logic [7:0]          r_frame_cnt;
    logic [7:0]          w_frame_cnt_next;
    logic                r_timeout_err;
    logic                w_timeout_err_next;

    logic                w_accept;
    logic [LANE_W-1:0]   w_wr_lane;
    logic [BEAT_W-1:0]   w_wr_addr;
    logic [LANES*SAMPLE_W-1:0] w_beat_data;

    // in_ready is decoded from state only, so it never depends on in_valid.
    assign w_accept  = (r_state == ST_FILL) && in_valid;

    // Sample n lands in bank (n % LANES) at address (n / LANES). A whole beat
    // is then one address read across all banks in parallel.
    assign w_wr_lane = r_wptr[LANE_W-1:0];
    assign w_wr_addr = r_wptr[PTR_W-1:LANE_W];

    // -------------------------------------------------------------------------
    // Frame buffer: one bank per lane.
    // The read is asynchronous so that beat 0 is already on the bus in the
    // first BURST cycle, which is the cycle right after the final accept.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_bank
            logic [SAMPLE_W-1:0] r_bank [BEATS];

            always_ff @(posedge clk) begin
                if (w_accept && (w_wr_lane == LANE_W'(gi))) begin
                    r_bank[w_wr_addr] <= in_sample;
                end
            end

            // Lane 0 occupies the most significant slice of the beat.
            assign w_beat_data[(LANES-1-gi)*SAMPLE_W +: SAMPLE_W] = r_bank[r_beat];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (sreset) begin
            r_state       <= ST_FILL;
            r_wptr        <= '0;
            r_beat        <= '0;
            r_wait_cnt    <= '0;
            r_frame_cnt   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_wptr        <= w_wptr_next;
            r_beat        <= w_beat_next;
            r_wait_cnt    <= w_wait_cnt_next;
            r_frame_cnt   <= w_frame_cnt_next;
            r_timeout_err <= w_timeout_err_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next       = r_state;
        w_wptr_next        = r_wptr;
        w_beat_next        = r_beat;
        w_wait_cnt_next    = r_wait_cnt;
        w_frame_cnt_next   = r_frame_cnt;
        w_timeout_err_next = 1'b0;

        case (r_state)
            ST_FILL: begin
                if (w_accept) begin
                    if (r_wptr == PTR_W'(N_POINTS - 1)) begin
                        w_state_next = ST_BURST;
                        w_wptr_next  = '0;
                        w_beat_next  = '0;
                    end else begin
                        w_wptr_next = r_wptr + 1'b1;
                    end
                end
            end

            // done is deliberately ignored here; only WAIT looks at it.
            ST_BURST: begin
                if (r_beat == BEAT_W'(BEATS - 1)) begin
                    w_state_next    = ST_WAIT;
                    w_beat_next     = '0;
                    w_wait_cnt_next = '0;
                end else begin
                    w_beat_next = r_beat + 1'b1;
                end
            end

            // done has priority over an expiring timeout in the same cycle.
            ST_WAIT: begin
                w_wait_cnt_next = r_wait_cnt + 1'b1;
                if (done) begin
                    w_state_next     = ST_FILL;
                    w_frame_cnt_next = r_frame_cnt + 8'd1;
                    w_wait_cnt_next  = '0;
                end else if (r_wait_cnt == WAIT_W'(DONE_TIMEOUT - 1)) begin
                    w_state_next       = ST_FILL;
                    w_timeout_err_next = 1'b1;
                    w_wait_cnt_next    = '0;
                end
            end

            default: begin
                w_state_next = ST_FILL;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs, decoded from registered state
    // -------------------------------------------------------------------------
    assign in_ready    = (r_state == ST_FILL);
    assign rel         = (r_state == ST_BURST);
    assign busy        = (r_state != ST_FILL);
    assign samples     = (r_state == ST_BURST) ? w_beat_data : '0;
    assign timeout_err = r_timeout_err;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_dft64_sample_loader.sv
// -----------------------------------------------------------------------------
// tb_dft64_sample_loader
//
// Self-checking bench for dft64_sample_loader.
// Expected beats are pushed to a queue as the samples are driven. They are
// popped and compared while the DUT bursts.
// -----------------------------------------------------------------------------
module tb_dft64_sample_loader;

    localparam int SAMPLE_W     = 16;
    localparam int N_POINTS     = 64;
    localparam int LANES        = 8;
    localparam int DONE_TIMEOUT = 6;

    logic                      clk       = 1'b0;
    logic                      sreset    = 1'b1;
    logic [SAMPLE_W-1:0]       in_sample = '0;
    logic                      in_valid  = 1'b0;
    logic                      in_ready;
    logic [LANES*SAMPLE_W-1:0] samples;
    logic                      rel;
    logic                      done      = 1'b0;
    logic                      busy;
    logic                      timeout_err;
    logic [7:0]                frame_cnt;

    always #5 clk = ~clk;

    dft64_sample_loader #(
        .SAMPLE_W     (SAMPLE_W),
        .N_POINTS     (N_POINTS),
        .LANES        (LANES),
        .DONE_TIMEOUT (DONE_TIMEOUT)
    ) dut (
        .clk         (clk),
        .sreset      (sreset),
        .in_sample   (in_sample),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .samples     (samples),
        .rel         (rel),
        .done        (done),
        .busy        (busy),
        .timeout_err (timeout_err),
        .frame_cnt   (frame_cnt)
    );

    int                        n_tests = 0;
    int                        n_fail  = 0;
    logic [LANES*SAMPLE_W-1:0] exp_q[$];
    logic [SAMPLE_W-1:0]       frame_data[N_POINTS];
    logic [7:0]                exp_frames = 8'd0;

    // Sampling point: 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_sine();
        real x;
        for (int n = 0; n < N_POINTS; n++) begin
            x = $sin(2.0 * 3.14159265358979 * 1000.0 * n / 48000.0) * 256.0;
            frame_data[n] = SAMPLE_W'($rtoi(x >= 0.0 ? x + 0.5 : x - 0.5));
        end
    endtask

    task automatic load_random();
        for (int n = 0; n < N_POINTS; n++) frame_data[n] = SAMPLE_W'($urandom);
    endtask

    // Drives frame_data as 64 accepts and pushes the expected beats.
    task automatic feed_frame(input string name, input bit gapped, input bit hold_valid);
        logic [LANES*SAMPLE_W-1:0] beat_v;
        beat_v = '0;
        for (int n = 0; n < N_POINTS; n++) begin
            if (gapped && n > 0) begin
                in_valid  = 1'b0;
                in_sample = 16'hBAD0;
                tick();
                n_tests++;
                if (rel !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s early_beat_gap n=%0d: rel=%b required 0", name, n, rel);
                end
            end
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL %s in_ready n=%0d: got %b required 1", name, n, in_ready);
            end
            in_valid  = 1'b1;
            in_sample = frame_data[n];
            beat_v[(LANES-1-(n%LANES))*SAMPLE_W +: SAMPLE_W] = frame_data[n];
            if (n % LANES == LANES - 1) begin
                exp_q.push_back(beat_v);
                beat_v = '0;
            end
            tick();
            if (n < N_POINTS - 1) begin
                n_tests++;
                if (rel !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s early_beat n=%0d: rel=%b required 0", name, n, rel);
                end
            end
        end
        if (hold_valid) in_sample = 16'h7EAD;
        else            in_valid  = 1'b0;
    endtask

    // Called right after the final accept. It ends on WAIT cycle 0.
    task automatic check_burst(input string name, input bit done_glitch);
        logic [LANES*SAMPLE_W-1:0] exp_beat;
        for (int b = 0; b < 8; b++) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s beat%0d: scoreboard empty, samples=%h", name, b, samples);
            end else begin
                exp_beat = exp_q.pop_front();
                if (rel !== 1'b1 || samples !== exp_beat) begin
                    n_fail++;
                    $display("FAIL %s beat%0d: rel=%b samples=%h required rel=1 samples=%h",
                             name, b, rel, samples, exp_beat);
                end
                $display("[TB] %s beat %0d samples=%h", name, b, samples);
            end
            n_tests++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s beat%0d_flags: in_ready=%b busy=%b required 0/1",
                         name, b, in_ready, busy);
            end
            done = done_glitch && (b == 2 || b == 3);
            tick();
        end
        done = 1'b0;
        n_tests++;
        if (rel !== 1'b0 || samples !== '0 || busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s wait_entry: rel=%b samples=%h busy=%b in_ready=%b required 0/0/1/0",
                     name, rel, samples, busy, in_ready);
        end
    endtask

    // Called on WAIT cycle 0. done is asserted on WAIT cycle wait_idx.
    task automatic finish_with_done(input string name, input int wait_idx);
        for (int c = 0; c < wait_idx; c++) begin
            n_tests++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s wait%0d: in_ready=%b busy=%b required 0/1", name, c, in_ready, busy);
            end
            tick();
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        exp_frames++;
        n_tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || frame_cnt !== exp_frames || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_done: in_ready=%b busy=%b frame_cnt=%0d timeout_err=%b required 1/0/%0d/0",
                     name, in_ready, busy, frame_cnt, timeout_err, exp_frames);
        end
        $display("[TB] %s frame done at wait cycle %0d, frame_cnt=%0d", name, wait_idx, frame_cnt);
    endtask

    task automatic test_reset();
        sreset   = 1'b1;
        in_valid = 1'b0;
        done     = 1'b0;
        tick();
        tick();
        sreset = 1'b0;
        exp_frames = 8'd0;
        n_tests++;
        if (in_ready !== 1'b1 || rel !== 1'b0 || samples !== '0 || frame_cnt !== 8'd0 ||
            timeout_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: in_ready=%b rel=%b samples=%h frame_cnt=%0d timeout_err=%b busy=%b required 1/0/0/0/0/0",
                     in_ready, rel, samples, frame_cnt, timeout_err, busy);
        end
        $display("[TB] reset in_ready=%b rel=%b frame_cnt=%0d", in_ready, rel, frame_cnt);
    endtask

    task automatic test_happy();
        load_sine();
        n_tests++;
        if (frame_data[0] !== 16'd0) begin
            n_fail++;
            $display("FAIL sine_s0: got %h required 0", frame_data[0]);
        end
        feed_frame("happy", 1'b0, 1'b0);
        check_burst("happy", 1'b0);
        finish_with_done("happy", 2);
    endtask

    // done is pulsed mid-burst; it must not shorten the burst or count a frame.
    task automatic test_gapped();
        load_sine();
        feed_frame("gapped", 1'b1, 1'b0);
        check_burst("gapped", 1'b1);
        n_tests++;
        if (frame_cnt !== exp_frames) begin
            n_fail++;
            $display("FAIL gapped done_in_burst: frame_cnt=%0d required %0d", frame_cnt, exp_frames);
        end
        finish_with_done("gapped", 2);
    endtask

    task automatic test_timeout();
        int cnt;
        load_random();
        feed_frame("timeout", 1'b0, 1'b0);
        check_burst("timeout", 1'b0);
        cnt = 0;
        while (busy === 1'b1 && cnt < 20) begin
            cnt++;
            n_tests++;
            if (timeout_err !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout early_err: wait cycle %0d timeout_err=%b required 0", cnt, timeout_err);
            end
            tick();
        end
        n_tests++;
        if (cnt != DONE_TIMEOUT || timeout_err !== 1'b1 || in_ready !== 1'b1 || frame_cnt !== exp_frames) begin
            n_fail++;
            $display("FAIL timeout: wait_cycles=%0d err=%b in_ready=%b frame_cnt=%0d required %0d/1/1/%0d",
                     cnt, timeout_err, in_ready, frame_cnt, DONE_TIMEOUT, exp_frames);
        end
        $display("[TB] timeout after %0d wait cycles, timeout_err=%b", cnt, timeout_err);
        tick();
        n_tests++;
        if (timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout pulse_width: timeout_err=%b required 0", timeout_err);
        end
    endtask

    // The fresh frame's done lands on the last WAIT cycle, so done must win over the timeout.
    task automatic test_reset_mid_burst();
        logic [LANES*SAMPLE_W-1:0] exp_beat;
        load_sine();
        feed_frame("midrst", 1'b0, 1'b0);
        for (int b = 0; b < 3; b++) begin
            exp_beat = exp_q.pop_front();
            n_tests++;
            if (rel !== 1'b1 || samples !== exp_beat) begin
                n_fail++;
                $display("FAIL midrst beat%0d: samples=%h required %h", b, samples, exp_beat);
            end
            tick();
        end
        n_tests++;
        if (rel !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst at_beat3: rel=%b required 1", rel);
        end
        sreset = 1'b1;
        tick();
        sreset = 1'b0;
        exp_q.delete();
        exp_frames = 8'd0;
        n_tests++;
        if (rel !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || samples !== '0 || frame_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL midrst after_reset: rel=%b in_ready=%b busy=%b frame_cnt=%0d required 0/1/0/0",
                     rel, in_ready, busy, frame_cnt);
        end
        $display("[TB] midrst reset applied at beat 3");
        load_random();
        feed_frame("midrst_fresh", 1'b0, 1'b0);
        check_burst("midrst_fresh", 1'b0);
        finish_with_done("midrst_fresh", DONE_TIMEOUT - 1);
    endtask

    // in_valid stays high with a junk value through BURST/WAIT.
    // The next frame must start with the first value presented after in_ready returns.
    task automatic test_backpressure();
        load_random();
        feed_frame("backpressure", 1'b0, 1'b1);
        check_burst("backpressure", 1'b0);
        finish_with_done("backpressure", 2);
        load_random();
        feed_frame("backpressure_next", 1'b0, 1'b0);
        check_burst("backpressure_next", 1'b0);
        finish_with_done("backpressure_next", 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_happy();
        test_gapped();
        test_timeout();
        test_reset_mid_burst();
        test_backpressure();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
